fpu_add_pipe: RTL and testbench
===============================

FPU_ADD_PIPE -- requirements
Module: fpu_add_pipe

Interface
REQ-001 SHALL have parameter C_EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter C_FRAC_W, default 23, fraction field width without the hidden bit.
REQ-003 SHALL have parameter C_TAG_W, default 4, width of the sideband tag.
REQ-004 SHALL use one clock and a synchronous, active-high reset: Clk_CI  in  1  rising-edge clock.
REQ-005 Rst_RI  in  1  synchronous active-high reset.
REQ-006 Valid_SI  in  1  input operands valid.
REQ-007 Ready_SO  out  1  block accepts an input this cycle.
REQ-008 Op_SI  in  1  operation select: 0 = a+b, 1 = a-b.
REQ-009 OpA_DI, OpB_DI  in  1+C_EXP_W+C_FRAC_W each  packed operands {sign, exp, frac}.
REQ-010 Tag_DI  in  C_TAG_W  sideband tag, returned unchanged with its result.
REQ-011 Valid_SO  out  1  result valid.
REQ-012 Ready_SI  in  1  downstream accepts the result.
REQ-013 Result_DO  out  1+C_EXP_W+C_FRAC_W  packed result.
REQ-014 Tag_DO  out  C_TAG_W  tag of the current result.
REQ-015 Ovf_SO, Inexact_SO  out  1 each  overflow flag and inexact flag of the current result.

Function
REQ-016 SHALL transfer on the input side when Valid_SI&&Ready_SO, and on the output side when Valid_SO&&Ready_SI.
REQ-017 SHALL be a 3-stage pipeline: S1 align, S2 add and leading-zero count, S3 normalise, round and pack.
- S1 align: compare exponents and then mantissas, swap operands so the larger magnitude is first, right-shift the smaller one, keep guard/round/sticky.
REQ-018 Latency SHALL be exactly 3 cycles from input transfer to Valid_SO when no stall occurs; throughput SHALL be 1 operation per cycle.
REQ-019 Each stage SHALL advance when it is empty or when the next stage advances.
- Ready_SO = ~V1 | (S1 advances).
- There is no combinational path from Valid_SI to Valid_SO.
REQ-020 When Ready_SI is low, Valid_SO, Result_DO, Tag_DO and the flags SHALL hold stable until the result transfers.
REQ-021 Results SHALL leave in acceptance order; no operation is lost or duplicated under any Ready_SI pattern.
REQ-022 Op_SI=1 SHALL invert the sign of operand b before the effective-operation decision; effective subtract = sign_a XOR sign_b_eff.
REQ-023 An input with exp==0 SHALL be treated as a signed zero (denormals flushed).
REQ-024 Alignment shifts of C_FRAC_W+3 or more SHALL fold the entire smaller mantissa into sticky.
REQ-025 Rounding SHALL be round-to-nearest-even only.
- Inexact_SO = guard|round|sticky before rounding.
- A rounding carry-out SHALL renormalise and increment the exponent.
REQ-026 An exact-zero result SHALL be +0, except -0 when both effective operands are negative zeros.
REQ-027 Exponent overflow after rounding SHALL produce signed infinity with Ovf_SO=1.
REQ-028 Exponent underflow SHALL flush to a signed zero with Inexact_SO=1.
REQ-029 The result sign SHALL be the sign of the larger-magnitude operand; on equal magnitudes under subtraction REQ-026 applies.

Reset
REQ-030 Rst_RI high at a rising edge SHALL clear all stage valid bits, discarding in-flight operations.
REQ-031 While Rst_RI is high, Ready_SO SHALL be 0.
REQ-032 Valid_SO, Result_DO, Tag_DO, Ovf_SO and Inexact_SO SHALL all read 0 in the cycle after reset.
REQ-033 Reset asserted mid-stream SHALL produce no Valid_SO pulse for pre-reset operations after reset releases.

Configuration
REQ-034 Macro FPU_ADD_PIPE_SPECIAL_EN defined SHALL enable IEEE special values:
- exp all-ones with frac==0 is infinity.
- inf + (-inf) (effective subtract) returns the canonical quiet NaN {0, all-ones, 1 followed by zeros}.
- Any NaN input returns the canonical quiet NaN.
- inf op finite returns that inf.
- Special values raise neither flag.
REQ-035 Macro FPU_ADD_PIPE_SPECIAL_EN undefined SHALL treat all-ones exponents as ordinary finite values; REQ-027 still produces the infinity encoding on overflow.

Verification (defaults, Op_SI=0 unless stated)
REQ-036 0x3F800000 + 0x3F800000 -> Result_DO=0x40000000 exactly 3 cycles later, flags 0, Tag_DO echoes Tag_DI.
REQ-037 0x3F800000 with Op_SI=1 and b=0x3F800000 -> 0x00000000; 0x80000000 + 0x80000000 -> 0x80000000.
REQ-038 Tie rounding:
- 0x3F800000 + 0x33800000 -> 0x3F800000 with Inexact_SO=1.
- 0x3F800001 + 0x33800000 -> 0x3F800002 with Inexact_SO=1.
REQ-039 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with Ovf_SO=1 and Inexact_SO=1.
REQ-040 Backpressure: issue 6 back-to-back ops with tags 0..5, hold Ready_SI=0 for 5 cycles, then 1.
- Ready_SO drops after 3 ops are held.
- All 6 results emerge in tag order 0..5 with outputs stable while stalled.
- Asserting reset mid-burst yields no further Valid_SO.
REQ-041 With FPU_ADD_PIPE_SPECIAL_EN: 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x7F800000 + 0x3F800000 -> 0x7F800000.

Source files
------------

// File: rtl/fpu_add_pipe.sv
// fpu_add_pipe: 3-stage floating-point adder/subtractor with valid/ready handshake, RNE rounding
// and denormal flush. Defining FPU_ADD_PIPE_SPECIAL_EN adds IEEE infinity/NaN handling.
module fpu_add_pipe #(
  parameter int C_EXP_W = 8,
  parameter int C_FRAC_W = 23,
  parameter int C_TAG_W = 4
) (
  input  logic                          Clk_CI,
  input  logic                          Rst_RI,
  input  logic                          Valid_SI,
  output logic                          Ready_SO,
  input  logic                          Op_SI,
  input  logic [C_EXP_W+C_FRAC_W:0]     OpA_DI,
  input  logic [C_EXP_W+C_FRAC_W:0]     OpB_DI,
  input  logic [C_TAG_W-1:0]            Tag_DI,
  output logic                          Valid_SO,
  input  logic                          Ready_SI,
  output logic [C_EXP_W+C_FRAC_W:0]     Result_DO,
  output logic [C_TAG_W-1:0]            Tag_DO,
  output logic                          Ovf_SO,
  output logic                          Inexact_SO
);
  localparam int E = C_EXP_W;
  localparam int F = C_FRAC_W;
  localparam int W = 1 + E + F;
  localparam int M = F + 4;
  localparam int N = F + 5;
  localparam int LW = $clog2(N + 1);
  logic v1, v2, v3, adv1, adv2, adv3;
  assign adv3 = ~v3 | Ready_SI;
  assign adv2 = ~v2 | adv3;
  assign adv1 = ~v1 | adv2;
  assign Ready_SO = adv1 & ~Rst_RI;
  assign Valid_SO = v3;
  logic sa, sb, za, zb, a_big, nan_i, inf_i, isgn_i;
  logic [E-1:0] ea, eb, el, es, d;
  logic [F-1:0] fa, fb;
  logic [W-2:0] mag_a, mag_b;
  logic [M-1:0] xa, xb, mbig, msml, al;
  logic [2*M-1:0] sh;
  assign sa = OpA_DI[W-1];
  assign sb = OpB_DI[W-1] ^ Op_SI;
  assign ea = OpA_DI[W-2:F];
  assign eb = OpB_DI[W-2:F];
  assign fa = OpA_DI[F-1:0];
  assign fb = OpB_DI[F-1:0];
  assign za = ~|ea;
  assign zb = ~|eb;
  assign mag_a = za ? '0 : OpA_DI[W-2:0];
  assign mag_b = zb ? '0 : OpB_DI[W-2:0];
  assign xa = za ? '0 : {1'b1, fa, 3'b000};
  assign xb = zb ? '0 : {1'b1, fb, 3'b000};
  assign a_big = mag_a >= mag_b;
  assign el = a_big ? ea : eb;
  assign es = a_big ? eb : ea;
  assign mbig = a_big ? xa : xb;
  assign msml = a_big ? xb : xa;
  assign d = el - es;
  assign sh = {msml, {M{1'b0}}} >> d;
  // shifted-out bits collapse into the sticky LSB
  assign al = (32'(d) >= F + 3) ? {{(M-1){1'b0}}, |msml} : {sh[2*M-1:M+1], sh[M] | (|sh[M-1:0])};
`ifdef FPU_ADD_PIPE_SPECIAL_EN
  assign nan_i = (&ea & |fa) | (&eb & |fb) | (&ea & ~|fa & &eb & ~|fb & (sa ^ sb));
  assign inf_i = (&ea & ~|fa) | (&eb & ~|fb);
  assign isgn_i = (&ea & ~|fa) ? sa : sb;
`else
  assign nan_i = 1'b0;
  assign inf_i = 1'b0;
  assign isgn_i = 1'b0;
`endif
  logic s1_sgn, s1_sub, s1_zs, s1_nan, s1_inf, s1_isgn;
  logic [E-1:0] s1_exp;
  logic [M-1:0] s1_ma, s1_mb;
  logic [C_TAG_W-1:0] s1_tag;
  logic [N-1:0] sum;
  logic [LW-1:0] lz;
  assign sum = s1_sub ? {1'b0, s1_ma} - {1'b0, s1_mb} : {1'b0, s1_ma} + {1'b0, s1_mb};
  always_comb begin
    lz = LW'(N);
    for (int i = 0; i < N; i++) if (sum[i]) lz = LW'(N - 1 - i);
  end
  logic s2_sgn, s2_zs, s2_nan, s2_inf, s2_isgn;
  logic [E-1:0] s2_exp;
  logic [N-1:0] s2_sum;
  logic [LW-1:0] s2_lz;
  logic [C_TAG_W-1:0] s2_tag;
  logic [N-1:0] n;
  logic [F+1:0] mr;
  logic [E+1:0] ex;
  logic [F-1:0] frac;
  logic g, r, st, rup, zero, unf, ovf, spc, ovf_f, inx_f;
  logic [W-1:0] res;
  assign n = s2_sum << s2_lz;
  assign g = n[3];
  assign r = n[2];
  assign st = |n[1:0];
  assign rup = g & (r | st | n[4]);
  assign mr = {1'b0, n[N-1:4]} + (F+2)'(rup);
  // a rounding carry-out renormalises by one and bumps the exponent
  assign ex = {2'b00, s2_exp} + (E+2)'(1) + (E+2)'(mr[F+1]) - (E+2)'(s2_lz);
  assign frac = mr[F+1] ? mr[F:1] : mr[F-1:0];
  assign zero = ~|s2_sum;
  assign unf = ex[E+1] | ~|ex;
  assign ovf = ex[E:0] >= {1'b0, {E{1'b1}}};
  assign spc = s2_nan | s2_inf;
  assign res = s2_nan ? {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}} :
               s2_inf ? {s2_isgn, {E{1'b1}}, {F{1'b0}}} :
               zero   ? {s2_zs, {(W-1){1'b0}}} :
               unf    ? {s2_sgn, {(W-1){1'b0}}} :
               ovf    ? {s2_sgn, {E{1'b1}}, {F{1'b0}}} :
                        {s2_sgn, ex[E-1:0], frac};
  assign ovf_f = ~spc & ~zero & ~unf & ovf;
  assign inx_f = ~spc & ~zero & (unf | ovf | g | r | st);
  always_ff @(posedge Clk_CI) begin
    if (adv1) begin
      s1_sgn <= a_big ? sa : sb;
      s1_sub <= sa ^ sb;
      s1_zs <= za & zb & sa & sb;
      s1_nan <= nan_i;
      s1_inf <= inf_i;
      s1_isgn <= isgn_i;
      s1_exp <= el;
      s1_ma <= mbig;
      s1_mb <= al;
      s1_tag <= Tag_DI;
    end
    if (adv2) begin
      s2_sgn <= s1_sgn;
      s2_zs <= s1_zs;
      s2_nan <= s1_nan;
      s2_inf <= s1_inf;
      s2_isgn <= s1_isgn;
      s2_exp <= s1_exp;
      s2_sum <= sum;
      s2_lz <= lz;
      s2_tag <= s1_tag;
    end
  end
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      Result_DO <= '0;
      Tag_DO <= '0;
      Ovf_SO <= 1'b0;
      Inexact_SO <= 1'b0;
    end else begin
      if (adv1) v1 <= Valid_SI;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
      if (adv3 && v2) begin
        Result_DO <= res;
        Tag_DO <= s2_tag;
        Ovf_SO <= ovf_f;
        Inexact_SO <= inx_f;
      end
    end
  end
endmodule

// File: tb/tb_fpu_add_pipe.sv
// tb_fpu_add_pipe: directed vectors for fpu_add_pipe at default widths, including backpressure and reset.
module tb_fpu_add_pipe;
  logic clk = 1'b0;
  logic rst, vin, rdy_o, op_s, vout, rdy_i, ovf_o, inx_o;
  logic [31:0] opa, opb, result;
  logic [3:0] tag, tag_o;
  int n_cmp = 0;
  int n_err = 0;
  int issued, got, pulses;
  logic stalled;
  logic [37:0] held;
  always #5 clk = ~clk;
  fpu_add_pipe dut (
    .Clk_CI(clk), .Rst_RI(rst), .Valid_SI(vin), .Ready_SO(rdy_o), .Op_SI(op_s),
    .OpA_DI(opa), .OpB_DI(opb), .Tag_DI(tag), .Valid_SO(vout), .Ready_SI(rdy_i),
    .Result_DO(result), .Tag_DO(tag_o), .Ovf_SO(ovf_o), .Inexact_SO(inx_o)
  );
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic run1(input string nm, input logic [31:0] a, input logic [31:0] b, input logic op,
                      input logic [3:0] tg, input logic [31:0] res, input logic ovf, input logic inx);
    @(negedge clk);
    vin = 1'b1; opa = a; opb = b; op_s = op; tag = tg;
    #1 check({nm, "_rdy"}, 64'(rdy_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_early"}, 64'(vout), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check(nm, 64'({vout, result, tag_o, ovf_o, inx_o}), 64'({1'b1, res, tg, ovf, inx}));
  endtask
  initial begin
    rst = 1'b1; vin = 1'b0; op_s = 1'b0; opa = '0; opb = '0; tag = '0; rdy_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 64'(rdy_o), 64'd0);
    check("rst_out", 64'({vout, result, tag_o, ovf_o, inx_o}), 64'd0);
    rst = 1'b0;
    run1("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 4'h5, 32'h40000000, 1'b0, 1'b0);
    run1("x_minus_x", 32'h3F800000, 32'h3F800000, 1'b1, 4'h1, 32'h00000000, 1'b0, 1'b0);
    run1("negz_plus_negz", 32'h80000000, 32'h80000000, 1'b0, 4'h2, 32'h80000000, 1'b0, 1'b0);
    run1("posz_plus_negz", 32'h00000000, 32'h80000000, 1'b0, 4'h3, 32'h00000000, 1'b0, 1'b0);
    run1("negz_minus_posz", 32'h80000000, 32'h00000000, 1'b1, 4'h4, 32'h80000000, 1'b0, 1'b0);
    run1("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 4'h6, 32'h3F800000, 1'b0, 1'b1);
    run1("tie_odd", 32'h3F800001, 32'h33800000, 1'b0, 4'h7, 32'h3F800002, 1'b0, 1'b1);
    run1("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'h8, 32'h7F800000, 1'b1, 1'b1);
    run1("two_minus_one", 32'h40000000, 32'h3F800000, 1'b1, 4'h9, 32'h3F800000, 1'b0, 1'b0);
    run1("swap_add", 32'h3F800000, 32'h40000000, 1'b0, 4'hA, 32'h40400000, 1'b0, 1'b0);
    run1("neg_result", 32'h3F800000, 32'h40000000, 1'b1, 4'hB, 32'hBF800000, 1'b0, 1'b0);
    run1("sign_cancel", 32'h3F800000, 32'hBF800000, 1'b0, 4'hC, 32'h00000000, 1'b0, 1'b0);
    run1("denorm_flush", 32'h00000001, 32'h3F800000, 1'b0, 4'hD, 32'h3F800000, 1'b0, 1'b0);
    run1("far_sticky", 32'h3F800000, 32'h00800000, 1'b0, 4'hE, 32'h3F800000, 1'b0, 1'b1);
    run1("underflow", 32'h00800001, 32'h00800000, 1'b1, 4'hF, 32'h00000000, 1'b0, 1'b1);
`ifdef FPU_ADD_PIPE_SPECIAL_EN
    run1("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 4'h1, 32'h7FC00000, 1'b0, 1'b0);
    run1("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 4'h2, 32'h7F800000, 1'b0, 1'b0);
    run1("nan_in", 32'h7F800001, 32'h3F800000, 1'b0, 4'h3, 32'h7FC00000, 1'b0, 1'b0);
`endif
    issued = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      rdy_i = cyc >= 5;
      vin = issued < 6;
      opa = 32'h3F800000 + (32'(issued) << 23);
      opb = opa; op_s = 1'b0; tag = 4'(issued);
      #1;
      if (cyc == 3) check("bp_rdy_drop", 64'(rdy_o), 64'd0);
      if (stalled) check("bp_hold", 64'({result, tag_o, ovf_o, inx_o}), 64'(held));
      stalled = vout && !rdy_i;
      held = {result, tag_o, ovf_o, inx_o};
      if (vout && rdy_i) begin
        check("bp_tag", 64'(tag_o), 64'(got));
        check("bp_res", 64'(result), 64'(32'h40000000 + (32'(got) << 23)));
        got++;
      end
      if (vin && rdy_o) issued++;
    end
    check("bp_count", 64'(got), 64'd6);
    check("bp_idle", 64'(vout), 64'd0);
    @(negedge clk);
    vin = 1'b1; opa = 32'h3F800000; opb = 32'h3F800000; tag = 4'h8;
    @(negedge clk);
    tag = 4'h9;
    @(negedge clk);
    vin = 1'b0; rst = 1'b1;
    #1 check("mid_rst_rdy", 64'(rdy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out", 64'({vout, result, tag_o, ovf_o, inx_o}), 64'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (vout) pulses++;
    end
    check("mid_rst_no_valid", 64'(pulses), 64'd0);
    run1("after_rst", 32'h3F800000, 32'h3F800000, 1'b0, 4'h3, 32'h40000000, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
